// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - per-channel button debouncer with early (lockout) or late (stability) detection
// Each channel has its own 2-flop synchronizer, FSM and counter; nothing is shared between channels.

module multi_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int DELAY_CYCLES = 2000000,
  parameter int MODE         = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] debounced_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  localparam int            CW       = $clog2(DELAY_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_CYCLES - 1);

  // Shared encoding: WAIT_* is the hold (MODE 0) or the stability check (MODE 1).
  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_out;
    logic          w_out_nxt;
    logic          r_rise;
    logic          r_fall;
    logic          w_s;
    logic          w_cnt_last;

    assign w_s        = r_sync2[n];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= ST_LOW;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_out   <= w_out_nxt;
        r_rise  <= w_out_nxt & ~r_out;
        r_fall  <= ~w_out_nxt & r_out;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      if (MODE == 0) begin
        // Early detection: follow the first edge, then ignore s for the whole hold.
        case (r_state)
          ST_LOW: begin
            w_out_nxt = 1'b0;
            if (w_s) begin
              w_out_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (w_cnt_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_HIGH;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
          ST_HIGH: begin
            w_out_nxt = 1'b1;
            if (!w_s) begin
              w_out_nxt   = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (w_cnt_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_LOW;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
          default: begin
            w_out_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOW;
          end
        endcase
      end else begin
        // Late detection: any reversion of s during the check cancels it.
        case (r_state)
          ST_LOW: begin
            w_out_nxt = 1'b0;
            if (w_s) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (!w_s) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_LOW;
            end else if (w_cnt_last) begin
              w_out_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_HIGH;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
          ST_HIGH: begin
            w_out_nxt = 1'b1;
            if (!w_s) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (w_s) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_HIGH;
            end else if (w_cnt_last) begin
              w_out_nxt   = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_LOW;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
          default: begin
            w_out_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOW;
          end
        endcase
      end
    end

    assign debounced_o[n] = r_out;
    assign rise_o[n]      = r_rise;
    assign fall_o[n]      = r_fall;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - bench for multi_debouncer, both modes side by side against a reference model
// The model works from sample history: lockout-since-last-change for MODE 0, stable-run length for MODE 1.

module tb_multi_debouncer;

  localparam int DLY = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] btn_i;
  logic [3:0] deb0, rise0, fall0;
  logic [3:0] deb1, rise1, fall1;

  multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(DLY), .MODE(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i),
    .debounced_o(deb0), .rise_o(rise0), .fall_o(fall0)
  );

  multi_debouncer #(.CHANNELS(4), .DELAY_CYCLES(DLY), .MODE(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i),
    .debounced_o(deb1), .rise_o(rise1), .fall_o(fall1)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_deb  [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic [3:0] m_h1, m_h2;
  int         m_since [4];
  int         m_run   [4];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_deb[m]  = '0;
      m_rise[m] = '0;
      m_fall[m] = '0;
    end
    m_h1 = '0;
    m_h2 = '0;
    for (int c = 0; c < 4; c++) begin
      m_since[c] = 1000;
      m_run[c]   = 0;
    end
  endfunction

  // s seen by the channel logic at an edge is the button level sampled two edges earlier.
  function automatic void model_edge();
    logic [3:0] s;
    for (int m = 0; m < 2; m++) begin
      m_rise[m] = '0;
      m_fall[m] = '0;
    end
    if (!rst_ni) begin
      model_reset();
    end else begin
      s    = m_h2;
      m_h2 = m_h1;
      m_h1 = btn_i;
      for (int c = 0; c < 4; c++) begin
        if (m_since[c] < 1000) m_since[c]++;
        if (m_since[c] > DLY && s[c] != m_deb[0][c]) begin
          m_deb[0][c] = s[c];
          m_since[c]  = 0;
          if (s[c]) m_rise[0][c] = 1'b1;
          else      m_fall[0][c] = 1'b1;
        end
        if (s[c] != m_deb[1][c]) m_run[c]++;
        else                     m_run[c] = 0;
        if (m_run[c] == DLY + 1) begin
          m_deb[1][c] = s[c];
          m_run[c]    = 0;
          if (s[c]) m_rise[1][c] = 1'b1;
          else      m_fall[1][c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("deb_m0",  32'(deb0),  32'(m_deb[0]));
    chk("rise_m0", 32'(rise0), 32'(m_rise[0]));
    chk("fall_m0", 32'(fall0), 32'(m_fall[0]));
    chk("deb_m1",  32'(deb1),  32'(m_deb[1]));
    chk("rise_m1", 32'(rise1), 32'(m_rise[1]));
    chk("fall_m1", 32'(fall1), 32'(m_fall[1]));
  endtask

  task automatic cycle(input logic [3:0] b);
    @(negedge clk_i);
    btn_i = b;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(b);
  endtask

  // Reset is asserted between edges so its asynchronous effect is observed before any clock.
  task automatic pulse_reset(input int n);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_deb0",  32'(deb0),  32'h0);
    chk("rst_async_rise0", 32'(rise0), 32'h0);
    chk("rst_async_deb1",  32'(deb1),  32'h0);
    for (int i = 0; i < n; i++) cycle(btn_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int         rise_cnt;
    int         fall_cnt;
    logic [3:0] b;

    rst_ni = 1'b1;
    btn_i  = '0;
    model_reset();
    #1;
    rst_ni = 1'b0;
    hold(4'b0000, 2);
    chk("reset_deb0",  32'(deb0),  32'h0);
    chk("reset_fall1", 32'(fall1), 32'h0);
    rst_ni = 1'b1;
    hold(4'b0000, 3);

    // Clean press on channel 0 in early mode.
    hold(4'b0001, 3);
    chk("clean_deb0_E2",  32'(deb0),  32'h1);
    chk("clean_rise0_E2", 32'(rise0), 32'h1);
    cycle(4'b0001);
    chk("clean_rise0_E3", 32'(rise0), 32'h0);
    chk("clean_deb0_E3",  32'(deb0),  32'h1);
    hold(4'b0001, 8);

    // Bouncing press on channel 1.
    rise_cnt = 0;
    cycle(4'b0011); rise_cnt += int'(rise0[1]);
    cycle(4'b0001); rise_cnt += int'(rise0[1]);
    cycle(4'b0011); rise_cnt += int'(rise0[1]);
    chk("bounce_deb0_E2", 32'(deb0), 32'h3);
    cycle(4'b0001); rise_cnt += int'(rise0[1]);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0011);
      rise_cnt += int'(rise0[1]);
    end
    chk("bounce_rise_count", 32'(rise_cnt), 32'd1);
    chk("bounce_deb0_end",   32'(deb0),     32'h3);
    hold(4'b0000, 14);

    // Late mode: short press rejected, long press accepted after E6.
    hold(4'b0100, 3);
    hold(4'b0000, 8);
    chk("short_press_deb1", 32'(deb1), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0100);
      if (i == 5) chk("long_press_deb1_E5", 32'(deb1), 32'h0);
      if (i == 6) begin
        chk("long_press_deb1_E6",  32'(deb1),  32'h4);
        chk("long_press_rise1_E6", 32'(rise1), 32'h4);
      end
    end

    // Late mode: two-cycle low glitch on a high channel is filtered.
    hold(4'b1100, 10);
    chk("glitch_pre_deb1", 32'(deb1), 32'hC);
    fall_cnt = 0;
    cycle(4'b0100); fall_cnt += int'(fall1[3]);
    cycle(4'b0100); fall_cnt += int'(fall1[3]);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1100);
      fall_cnt += int'(fall1[3]);
    end
    chk("glitch_fall_count", 32'(fall_cnt), 32'd0);
    chk("glitch_deb1_end",   32'(deb1),     32'hC);
    hold(4'b0000, 14);

    // Reset in the middle of a hold, button kept pressed through release.
    hold(4'b0001, 4);
    pulse_reset(2);
    cycle(4'b0001);
    chk("rst_rel_deb0_1", 32'(deb0), 32'h0);
    cycle(4'b0001);
    chk("rst_rel_deb0_2", 32'(deb0), 32'h0);
    cycle(4'b0001);
    chk("rst_rel_deb0_3",  32'(deb0),  32'h1);
    chk("rst_rel_rise0_3", 32'(rise0), 32'h1);
    hold(4'b0001, 10);
    hold(4'b0000, 14);

    // All channels pressed on the same edge.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111);
      if (i == 2) begin
        chk("all_deb0_E2",  32'(deb0),  32'hF);
        chk("all_rise0_E2", 32'(rise0), 32'hF);
        chk("all_deb1_E2",  32'(deb1),  32'h0);
      end
      if (i == 6) begin
        chk("all_deb1_E6",  32'(deb1),  32'hF);
        chk("all_rise1_E6", 32'(rise1), 32'hF);
      end
    end
    hold(4'b0000, 14);

    // Random bouncing with a reset pulse midway.
    b = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 9) == 0) b[c] = ~b[c];
      end
      if (i == 300) begin
        btn_i = b;
        pulse_reset(1 + int'($urandom_range(0, 2)));
      end
      cycle(b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent button channels (range 1..32).
REQ-002 The block SHALL have parameter DELAY_CYCLES, default 2000000, giving the debounce window in clk_i cycles (range 2..2^24).
REQ-003 The block SHALL have parameter MODE, default 0: 0 = early detection (act on first edge, then lock out); 1 = late detection (act only after the input has been stable).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_i, input, CHANNELS bits: raw, asynchronous, bouncing button inputs, one per channel.
REQ-007 The block SHALL have port debounced_o, output, CHANNELS bits: the registered debounced level per channel.
REQ-008 The block SHALL have port rise_o, output, CHANNELS bits: a one-cycle pulse in the first cycle that debounced_o[n] reads 1.
REQ-009 The block SHALL have port fall_o, output, CHANNELS bits: a one-cycle pulse in the first cycle that debounced_o[n] reads 0 after having been 1.

Function
REQ-010 Each channel SHALL be fully independent; no shared counter and no cross-channel interaction.
REQ-011 Each btn_i bit SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-stage output s[n].
REQ-012 Each channel counter SHALL be $clog2(DELAY_CYCLES+1) bits wide, SHALL be cleared on every state entry, and SHALL never wrap.
REQ-013 In MODE=0, each channel SHALL implement 4 states:
- IDLE: out=0; s=1 -> out=1, cnt=0, go to HOLD_HI.
- HOLD_HI: s is ignored; at cnt==DELAY_CYCLES-1 go to HIGH; otherwise cnt+1.
- HIGH: out=1; s=0 -> out=0, cnt=0, go to HOLD_LO.
- HOLD_LO: s is ignored; at cnt==DELAY_CYCLES-1 go to IDLE; otherwise cnt+1.
REQ-014 In MODE=1, each channel SHALL implement 4 states:
- LOW: out=0; s=1 -> cnt=0, go to CHK_HI.
- CHK_HI: s=0 -> go to LOW; s=1 with cnt==DELAY_CYCLES-1 -> out=1, go to HIGH; otherwise cnt+1.
- HIGH: out=1; s=0 -> cnt=0, go to CHK_LO.
- CHK_LO: s=1 -> go to HIGH; s=0 with cnt==DELAY_CYCLES-1 -> out=0, go to LOW; otherwise cnt+1.
REQ-015 Latency, counting btn_i stable before clock edge E0:
- MODE=0: debounced_o SHALL change after edge E2.
- MODE=1: debounced_o SHALL change after edge E2+DELAY_CYCLES, and only if s stayed constant throughout.
REQ-016 In MODE=0, input activity during HOLD_HI/HOLD_LO SHALL have no effect; a level differing from out when the hold expires SHALL be acted on in the following cycle.
REQ-017 rise_o/fall_o SHALL be registered, asserted for exactly one cycle per debounced_o transition, and never asserted together on one channel.
REQ-018 Any illegal state encoding SHALL return to IDLE/LOW with out=0 on the next edge.
REQ-019 Simultaneous transitions on several channels SHALL each be processed in the same cycle, without priority.

Reset
REQ-020 While rst_ni=0, all synchronizer flops, counters, debounced_o, rise_o and fall_o SHALL be 0, and every FSM SHALL be in IDLE/LOW, asynchronously.
REQ-021 Assertion of reset mid-hold or mid-check SHALL abort that hold or check immediately, with no output pulse.
REQ-022 After rst_ni deasserts, a btn_i held high SHALL be treated as a new press, producing a rise_o pulse with the normal latency.

Verification (CHANNELS=4, DELAY_CYCLES=4)
REQ-023 The bench SHALL cover: MODE=0, btn_i[0] 0->1 clean -> debounced_o[0]=1 and rise_o[0]=1 after edge E2, rise_o[0]=0 after E3, other channels stay 0.
REQ-024 The bench SHALL cover: MODE=0, btn_i[1] bounces 1,0,1,0 at one cycle each from E0, then holds 1 -> debounced_o[1] rises once after E2 and stays 1; exactly one rise_o pulse.
REQ-025 The bench SHALL cover: MODE=1, btn_i[2] high for 3 cycles then low -> debounced_o[2] stays 0; held high for 6 cycles -> rises after E6.
REQ-026 The bench SHALL cover: MODE=1, debounced_o[3]=1, btn_i[3] glitches low for 2 cycles -> no fall_o pulse, debounced_o[3] stays 1.
REQ-027 The bench SHALL cover: MODE=0, rst_ni driven low two cycles into HOLD_HI -> all outputs 0 immediately; with btn_i still high after release -> one rise_o pulse 3 edges after release.
REQ-028 The bench SHALL cover: all 4 channels pressed on the same edge in both modes -> all debounced_o bits and all rise_o bits assert on the same cycle.
